// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: writeback stage first, MDU results
// drain from a small FIFO; busy scoreboard and starvation-forced stall.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   pipe_*         : writeback stage write request
//   md_start*      : MDU issue (sets busy bit)
//   md_*           : MDU result handshake (valid/ready), exception redirect
//   pipe_stall     : one-cycle writeback freeze
//   busy_mask      : pending MDU destinations
//   waw_err        : sticky pipeline write to a busy register
//   ctrl_*, data_* : registered regfile write port
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic        md_start,
  input  logic [4:0]  md_start_reg,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic        md_exception,
  output logic        pipe_stall,
  output logic [31:0] busy_mask,
  output logic        waw_err,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [4:0]  dst_q [DEPTH];
  logic [4:0]  clr_q [DEPTH];
  logic [31:0] dat_q [DEPTH];

  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] stv_q, stv_d;
  logic          stall_q, stall_d;
  logic          en_q;
  logic [31:0]   busy_q, busy_d;
  logic          waw_q, waw_d;
  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdat_q, wdat_d;

  logic grant, pop, push, empty;

  assign empty = (cnt_q == '0);
  // While the forced stall is up the FIFO is non-empty and pops for
  // sure, so a full FIFO may take a new entry in that same cycle.
  assign md_ready = en_q && ((cnt_q != FULL) || stall_q);

  always_comb begin
    grant  = pipe_we && !stall_q;
    pop    = !grant && !empty;
    push   = md_valid && md_ready;
    we_d   = 1'b0;
    wreg_d = wreg_q;
    wdat_d = wdat_q;
    if (grant) begin
      we_d   = (pipe_reg != 5'd0);
      wreg_d = pipe_reg;
      wdat_d = pipe_data;
    end else if (pop) begin
      we_d   = (dst_q[rd_q] != 5'd0);
      wreg_d = dst_q[rd_q];
      wdat_d = dat_q[rd_q];
    end

    stall_d = 1'b0;
    stv_d   = stv_q;
    if (pop || empty) begin
      stv_d = '0;
    end else if (grant) begin
      stv_d = stv_q + 1'b1;
      if (stv_d == LIM) begin
        stall_d = 1'b1;
        stv_d   = '0;
      end
    end

    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;

    busy_d = busy_q;
    if (pop) busy_d[clr_q[rd_q]] = 1'b0;
    if (md_start && md_start_reg != 5'd0)
      busy_d[md_start_reg] = 1'b1;

    waw_d = waw_q ||
      (grant && pipe_reg != 5'd0 && busy_q[pipe_reg]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i] <= '0;
        clr_q[i] <= '0;
        dat_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      stv_q   <= '0;
      stall_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= '0;
      waw_q   <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdat_q  <= '0;
    end else begin
      if (push) begin
        dst_q[wr_q] <= md_exception ? 5'd30 : md_reg;
        clr_q[wr_q] <= md_reg;
        dat_q[wr_q] <= md_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      stv_q   <= stv_d;
      stall_q <= stall_d;
      en_q    <= 1'b1;
      busy_q  <= busy_d;
      waw_q   <= waw_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdat_q  <= wdat_d;
    end
  end

  assign pipe_stall       = stall_q;
  assign busy_mask        = busy_q;
  assign waw_err          = waw_q;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdat_q;

endmodule
